z80_bus_bridge: RTL and testbench
=================================

Z80_BUS_BRIDGE -- requirements
Module: z80_bus_bridge

Interface
REQ-001 SHALL have parameter TIMEOUT, default 255, meaning ack-wait cycles before abort (range 1..255, 8-bit counter).
REQ-002 SHALL have port clk  input  1  single clock, rising edge.
REQ-003 SHALL have port reset_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have CPU-side inputs A (16), dout (8), m1_n, mreq_n, iorq_n, rd_n, wr_n, rfsh_n (1 each), all synchronous to clk.
REQ-005 SHALL have CPU-side outputs di (8, read data to CPU) and wait_n (1, active-low wait).
REQ-006 SHALL have input int_vec (8), the vector returned on interrupt acknowledge.
REQ-007 SHALL have memory-side outputs mem_req (1), mem_we (1), mem_io (1), mem_addr (16), mem_wdata (8).
REQ-008 SHALL have memory-side inputs mem_rdata (8) and mem_ack (1).
REQ-009 SHALL have output bus_err (1, sticky timeout flag) and input err_clr (1, synchronous clear).

Function
REQ-010 Memory cycle = mreq_n=0 and rfsh_n=1 and (rd_n=0 or wr_n=0).
REQ-011 I/O cycle = iorq_n=0 and m1_n=1 and (rd_n=0 or wr_n=0).
REQ-012 INTA cycle = m1_n=0 and iorq_n=0: di SHALL equal int_vec combinationally; no mem_req; wait_n stays 1.
REQ-013 Refresh cycles (rfsh_n=0) SHALL be ignored: no mem_req, wait_n=1.
REQ-014 FSM states: IDLE, REQ, DONE.
REQ-015 IDLE, qualifying cycle seen: capture A->mem_addr, dout->mem_wdata, (wr_n=0)->mem_we, I/O->mem_io; clear timeout counter; go REQ.
REQ-016 wait_n SHALL be 0 combinationally whenever a memory/I/O cycle is active and state is IDLE or REQ, including the detection cycle.
REQ-017 REQ: mem_req=1; mem_addr/we/io/wdata held stable.
REQ-018 REQ, mem_ack=1: read -> register mem_rdata into di; write -> di unchanged; mem_req=0 next cycle; go DONE.
REQ-019 REQ, no ack, counter reaches TIMEOUT: abort; di=0xFF; bus_err=1; mem_req=0; go DONE.
REQ-020 mem_ack on the same edge as timeout SHALL win (normal completion, no bus_err).
REQ-021 DONE: wait_n=1; remain until rd_n=1 and wr_n=1, then IDLE (no back-to-back re-trigger on same strobe).
REQ-022 mem_ack outside REQ SHALL be ignored.
REQ-023 Latency: mem_req asserted first edge after strobe detection; wait_n released first edge after ack; one request per bus cycle.
REQ-024 bus_err: set on timeout, cleared by err_clr=1; simultaneous set and clear -> set wins.
REQ-025 di outside INTA SHALL hold last registered value.

Reset
REQ-026 reset_n=0 SHALL asynchronously force: state IDLE, mem_req=0, mem_we=0, mem_io=0, mem_addr=0x0000, mem_wdata=0x00, di=0xFF, bus_err=0, counter=0; wait_n=1 unless a cycle is active.
REQ-027 Reset mid-REQ SHALL drop mem_req immediately; pending transaction discarded, no retry.

Configuration
REQ-028 Macro Z80_BRIDGE_IO_EN defined: I/O cycles forwarded per REQ-015..019 with mem_io=1.
REQ-029 Macro Z80_BRIDGE_IO_EN undefined: I/O cycles SHALL not assert mem_req or wait_n; reads return di=0xFF; writes discarded; mem_io tied 0.

Verification
REQ-030 Mem read A=0x1234, mem_ack 3 cycles after mem_req, mem_rdata=0xA5 -> mem_addr=0x1234, mem_we=0, wait_n low 4 cycles, di=0xA5.
REQ-031 Mem write A=0x8000, dout=0x3C, immediate ack -> mem_we=1, mem_wdata=0x3C, single mem_req pulse, wait_n released next edge.
REQ-032 INTA with int_vec=0xFF then 0x38 -> di tracks vector same cycle, mem_req never asserted.
REQ-033 Mem read, no ack, TIMEOUT=4 -> abort after 4 REQ cycles, di=0xFF, bus_err=1; err_clr pulse -> bus_err=0.
REQ-034 I/O read port 0x0010: with Z80_BRIDGE_IO_EN mem_io=1 and rdata returned; without it di=0xFF, no mem_req.
REQ-035 reset_n low while in REQ -> mem_req=0 asynchronously, di=0xFF; next read completes normally.

Source files
------------

// File: rtl/z80_bus_bridge.sv
// Z80 CPU bus to single-request memory/IO bus bridge with ack timeout and sticky error.
// Optional feature: define Z80_BRIDGE_IO_EN to forward I/O cycles (otherwise they are absorbed locally).
module z80_bus_bridge #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [15:0] A,
  input  logic [7:0]  dout,
  input  logic        m1_n,
  input  logic        mreq_n,
  input  logic        iorq_n,
  input  logic        rd_n,
  input  logic        wr_n,
  input  logic        rfsh_n,
  output logic [7:0]  di,
  output logic        wait_n,
  input  logic [7:0]  int_vec,
  output logic        mem_req,
  output logic        mem_we,
  output logic        mem_io,
  output logic [15:0] mem_addr,
  output logic [7:0]  mem_wdata,
  input  logic [7:0]  mem_rdata,
  input  logic        mem_ack,
  output logic        bus_err,
  input  logic        err_clr
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [7:0] LP_TO_LAST = 8'(TIMEOUT - 1);

  state_t      r_state;
  state_t      w_state_nxt;
  logic [7:0]  r_cnt;
  logic [15:0] r_addr;
  logic [7:0]  r_wdata;
  logic        r_we;
  logic        r_io;
  logic        r_req;
  logic [7:0]  r_di;
  logic        r_err;

  logic w_mem_cyc;
  logic w_io_cyc;
  logic w_inta;
  logic w_io_fwd;
  logic w_io_drop;
  logic w_fwd;
  logic w_capture;
  logic w_done;
  logic w_abort;

  assign w_mem_cyc = ~mreq_n & rfsh_n & (~rd_n | ~wr_n);
  assign w_io_cyc  = ~iorq_n & m1_n & (~rd_n | ~wr_n);
  assign w_inta    = ~m1_n & ~iorq_n;

`ifdef Z80_BRIDGE_IO_EN
  assign w_io_fwd  = w_io_cyc;
  assign w_io_drop = 1'b0;
`else
  assign w_io_fwd  = 1'b0;
  assign w_io_drop = w_io_cyc;
`endif

  assign w_fwd = w_mem_cyc | w_io_fwd;

  // Next-state decode; ack is checked before the timeout so a late ack still completes normally.
  always_comb begin
    w_state_nxt = r_state;
    w_capture   = 1'b0;
    w_done      = 1'b0;
    w_abort     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_fwd) begin
          w_state_nxt = S_REQ;
          w_capture   = 1'b1;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_REQ: begin
        if (mem_ack) begin
          w_state_nxt = S_DONE;
          w_done      = 1'b1;
        end else if (r_cnt == LP_TO_LAST) begin
          w_state_nxt = S_DONE;
          w_abort     = 1'b1;
        end else begin
          w_state_nxt = S_REQ;
        end
      end
      S_DONE: begin
        if (rd_n && wr_n) begin
          w_state_nxt = S_IDLE;
        end else begin
          w_state_nxt = S_DONE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Request capture, timeout counter, read data and sticky error.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt   <= 8'd0;
      r_addr  <= 16'h0000;
      r_wdata <= 8'h00;
      r_we    <= 1'b0;
      r_io    <= 1'b0;
      r_req   <= 1'b0;
      r_di    <= 8'hFF;
      r_err   <= 1'b0;
    end else begin
      if (w_capture) begin
        r_addr  <= A;
        r_wdata <= dout;
        r_we    <= ~wr_n;
        r_io    <= w_io_fwd & ~w_mem_cyc;
        r_cnt   <= 8'd0;
        r_req   <= 1'b1;
      end else if (w_done || w_abort) begin
        r_req <= 1'b0;
      end else if (r_state == S_REQ) begin
        r_cnt <= r_cnt + 8'd1;
      end

      // Absorbed I/O reads float the bus high, as an empty Z80 port would.
      if (w_done && !r_we) begin
        r_di <= mem_rdata;
      end else if (w_abort) begin
        r_di <= 8'hFF;
      end else if ((r_state == S_IDLE) && w_io_drop && !rd_n) begin
        r_di <= 8'hFF;
      end

      if (w_abort) begin
        r_err <= 1'b1;
      end else if (err_clr) begin
        r_err <= 1'b0;
      end
    end
  end

  assign wait_n    = ~(w_fwd & ((r_state == S_IDLE) | (r_state == S_REQ)));
  assign di        = w_inta ? int_vec : r_di;
  assign mem_req   = r_req;
  assign mem_we    = r_we;
  assign mem_io    = r_io;
  assign mem_addr  = r_addr;
  assign mem_wdata = r_wdata;
  assign bus_err   = r_err;

endmodule

// File: tb/tb_z80_bus_bridge.sv
// Randomized scoreboard bench for z80_bus_bridge (TIMEOUT=4); a memory responder answers requests
// after a chosen delay and a monitor checks each completed request against the queued expectation.
module tb_z80_bus_bridge;

  localparam int TMO = 4;
`ifdef Z80_BRIDGE_IO_EN
  localparam bit IO_EN = 1'b1;
`else
  localparam bit IO_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset_n;
  logic [15:0] A;
  logic [7:0]  dout;
  logic        m1_n, mreq_n, iorq_n, rd_n, wr_n, rfsh_n;
  logic [7:0]  di;
  logic        wait_n;
  logic [7:0]  int_vec;
  logic        mem_req, mem_we, mem_io;
  logic [15:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic [7:0]  mem_rdata;
  logic        mem_ack;
  logic        bus_err;
  logic        err_clr;

  z80_bus_bridge #(.TIMEOUT(TMO)) dut (
    .clk(clk), .reset_n(reset_n), .A(A), .dout(dout), .m1_n(m1_n), .mreq_n(mreq_n),
    .iorq_n(iorq_n), .rd_n(rd_n), .wr_n(wr_n), .rfsh_n(rfsh_n), .di(di), .wait_n(wait_n),
    .int_vec(int_vec), .mem_req(mem_req), .mem_we(mem_we), .mem_io(mem_io),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .bus_err(bus_err), .err_clr(err_clr)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] addr;
    logic [7:0]  wdata;
    logic        we;
    logic        io;
    int          cycles;
    logic [7:0]  rdi;
    logic        err;
  } exp_t;

  exp_t       sb[$];
  int         vectors = 0;
  int         errors = 0;
  int         done_cnt = 0;
  int         cur_delay = 0;
  logic [7:0] cur_rdata = 8'h00;
  logic [7:0] model_di = 8'hFF;
  logic       model_err = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Memory responder: acks in REQ cycle index cur_delay, random noise on ack otherwise.
  initial begin
    int rc;
    rc = 0;
    mem_ack = 1'b0;
    mem_rdata = 8'h00;
    forever begin
      @(negedge clk);
      if (!reset_n || !mem_req) begin
        rc = 0;
        mem_ack = 1'($urandom_range(0, 1));
        mem_rdata = 8'($urandom);
      end else begin
        mem_ack = (rc == cur_delay);
        mem_rdata = (rc == cur_delay) ? cur_rdata : 8'($urandom);
        rc++;
      end
    end
  end

  // Monitor: pops an expectation on each mem_req rise and checks the outcome when it falls.
  initial begin
    exp_t cur;
    logic prev_req, active;
    int   req_cnt, wl_cnt;
    prev_req = 1'b0;
    active = 1'b0;
    req_cnt = 0;
    wl_cnt = 0;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        prev_req = 1'b0;
        active = 1'b0;
      end else begin
        if (mem_req && !prev_req) begin
          if (sb.size() == 0) begin
            check("spurious_req", 32'(mem_req), 32'd0);
          end else begin
            cur = sb.pop_front();
            active = 1'b1;
            req_cnt = 0;
            wl_cnt = 0;
            check("mem_we", 32'(mem_we), 32'(cur.we));
            check("mem_io", 32'(mem_io), 32'(cur.io));
            check("mem_wdata", 32'(mem_wdata), 32'(cur.wdata));
          end
        end
        if (mem_req && active) begin
          req_cnt++;
          if (!wait_n) wl_cnt++;
          check("mem_addr", 32'(mem_addr), 32'(cur.addr));
        end
        if (!mem_req && prev_req && active) begin
          check("req_cycles", 32'(req_cnt), 32'(cur.cycles));
          check("wait_low_cycles", 32'(wl_cnt), 32'(cur.cycles));
          check("wait_release", 32'(wait_n), 32'd1);
          check("di_done", 32'(di), 32'(cur.rdi));
          check("bus_err_done", 32'(bus_err), 32'(cur.err));
          active = 1'b0;
          done_cnt++;
        end
        prev_req = mem_req;
      end
    end
  end

  task automatic bus_idle();
    A = 16'h0000; dout = 8'h00;
    m1_n = 1'b1; mreq_n = 1'b1; iorq_n = 1'b1; rd_n = 1'b1; wr_n = 1'b1; rfsh_n = 1'b1;
  endtask

  // kind: 0 mem rd, 1 mem wr, 2 io rd, 3 io wr
  task automatic do_op(input int kind, input logic [15:0] addr, input logic [7:0] data,
                       input int delay, input logic [7:0] rdata, input logic clr);
    logic is_mem, is_io, is_rd, fwd, tmo;
    exp_t e;
    int   start, n;
    is_mem = (kind < 2);
    is_io  = (kind == 2) || (kind == 3);
    is_rd  = (kind == 0) || (kind == 2);
    fwd    = is_mem || (is_io && IO_EN);
    @(posedge clk); #1;
    A = addr; dout = data; err_clr = clr;
    rd_n = ~is_rd; wr_n = is_rd; mreq_n = ~is_mem; iorq_n = ~is_io;
    if (fwd) begin
      tmo = (delay >= TMO);
      e.addr = addr; e.wdata = data; e.we = ~is_rd; e.io = is_io;
      e.cycles = tmo ? TMO : delay + 1;
      e.rdi = tmo ? 8'hFF : (is_rd ? rdata : model_di);
      e.err = tmo ? 1'b1 : (clr ? 1'b0 : model_err);
      sb.push_back(e);
      cur_delay = delay;
      cur_rdata = rdata;
      #1 check("wait_detect", 32'(wait_n), 32'd0);
      start = done_cnt;
      n = 0;
      while (done_cnt == start && n < 40) begin
        @(posedge clk);
        n++;
      end
      check("done_seen", 32'(done_cnt), 32'(start + 1));
      model_di = e.rdi;
      model_err = e.err;
    end else begin
      #1 check("wait_nofwd", 32'(wait_n), 32'd1);
      repeat (3) begin
        @(posedge clk); #1;
        check("noreq_io", 32'(mem_req), 32'd0);
        check("wait_io", 32'(wait_n), 32'd1);
      end
      if (is_rd) model_di = 8'hFF;
      check("di_io_absorbed", 32'(di), 32'(model_di));
    end
    @(posedge clk); #1;
    bus_idle();
    err_clr = 1'b0;
    if (clr) model_err = 1'b0;
    @(posedge clk); #1;
    check("bus_err_idle", 32'(bus_err), 32'(model_err));
    check("di_idle", 32'(di), 32'(model_di));
  endtask

  task automatic do_inta(input logic [7:0] v1, input logic [7:0] v2);
    @(posedge clk); #1;
    m1_n = 1'b0; iorq_n = 1'b0; int_vec = v1;
    #1 check("inta_vec1", 32'(di), 32'(v1));
    check("inta_wait", 32'(wait_n), 32'd1);
    @(posedge clk); #1;
    int_vec = v2;
    #1 check("inta_vec2", 32'(di), 32'(v2));
    check("inta_noreq", 32'(mem_req), 32'd0);
    @(posedge clk); #1;
    bus_idle();
    #1 check("inta_di_after", 32'(di), 32'(model_di));
  endtask

  task automatic do_refresh();
    @(posedge clk); #1;
    mreq_n = 1'b0; rfsh_n = 1'b0; rd_n = 1'b0; A = 16'($urandom);
    repeat (2) begin
      #1 check("rfsh_wait", 32'(wait_n), 32'd1);
      @(posedge clk); #1;
      check("rfsh_noreq", 32'(mem_req), 32'd0);
    end
    bus_idle();
  endtask

  task automatic do_reset_mid_req();
    int n;
    @(posedge clk); #1;
    A = 16'h4321; rd_n = 1'b0; mreq_n = 1'b0;
    cur_delay = 100;
    sb.push_back('{16'h4321, 8'h00, 1'b0, 1'b0, TMO, 8'hFF, 1'b1});
    n = 0;
    while (!mem_req && n < 10) begin
      @(posedge clk); #1;
      n++;
    end
    check("reset_req_seen", 32'(mem_req), 32'd1);
    #2 reset_n = 1'b0;
    #1 check("reset_req_drop", 32'(mem_req), 32'd0);
    check("reset_di", 32'(di), 32'hFF);
    check("reset_err", 32'(bus_err), 32'd0);
    sb.delete();
    model_di = 8'hFF;
    model_err = 1'b0;
    @(posedge clk); #1;
    reset_n = 1'b1;
    bus_idle();
    @(posedge clk); #1;
    check("reset_noretry", 32'(mem_req), 32'd0);
  endtask

  initial begin
    bus_idle();
    reset_n = 1'b0;
    err_clr = 1'b0;
    int_vec = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    check("rst_mem_req", 32'(mem_req), 32'd0);
    check("rst_mem_we", 32'(mem_we), 32'd0);
    check("rst_mem_io", 32'(mem_io), 32'd0);
    check("rst_mem_addr", 32'(mem_addr), 32'h0000);
    check("rst_mem_wdata", 32'(mem_wdata), 32'h00);
    check("rst_di", 32'(di), 32'hFF);
    check("rst_bus_err", 32'(bus_err), 32'd0);
    check("rst_wait_n", 32'(wait_n), 32'd1);
    reset_n = 1'b1;

    do_op(0, 16'h1234, 8'h00, 3, 8'hA5, 1'b0);
    do_op(1, 16'h8000, 8'h3C, 0, 8'h00, 1'b0);
    do_inta(8'hFF, 8'h38);
    do_op(0, 16'h2222, 8'h00, 10, 8'h11, 1'b0);
    @(posedge clk); #1;
    err_clr = 1'b1;
    @(posedge clk); #1;
    err_clr = 1'b0;
    model_err = 1'b0;
    check("err_clr_pulse", 32'(bus_err), 32'd0);
    do_op(0, 16'h3333, 8'h00, 6, 8'h22, 1'b1);
    do_op(2, 16'h0010, 8'h00, 1, 8'h5A, 1'b0);
    do_op(3, 16'h0010, 8'h77, 0, 8'h00, 1'b0);
    do_refresh();
    do_reset_mid_req();
    do_op(0, 16'h1234, 8'h00, 2, 8'hC3, 1'b0);

    for (int i = 0; i < 80; i++) begin
      int k;
      k = $urandom_range(0, 5);
      if (k == 4) begin
        do_inta(8'($urandom), 8'($urandom));
      end else if (k == 5) begin
        do_refresh();
      end else begin
        do_op(k, 16'($urandom), 8'($urandom), $urandom_range(0, 5), 8'($urandom),
              1'($urandom_range(0, 3) == 0));
      end
    end

    repeat (3) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
